// File: rtl/adder_pkg.sv
// Shared sizing helpers for the streaming adder tree.
package adder_pkg;

  function automatic int levels(input int num);
    return $clog2(num);
  endfunction

  function automatic int obits(input int bits, input int num, input int grow);
    return (grow != 0) ? bits + $clog2(num) : bits;
  endfunction

  // Node count entering tree level lvl; odd leftovers round up.
  function automatic int nodes_at(input int num, input int lvl);
    int n;
    n = num;
    for (int j = 0; j < lvl; j++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic longint unsigned sat_max(input int bits);
    return (64'd1 << bits) - 64'd1;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One tree level: pair adjacent nodes, add (grow, wrap or saturate), register with bubble-collapsing load.
module adder_tree_level import adder_pkg::*; #(
  parameter int IN_NODES = 4,
  parameter int IN_BITS  = 8,
  parameter int GROW     = 0,
  parameter int SAT      = 0,
  localparam int OUT_NODES = (IN_NODES + 1) / 2,
  localparam int OUT_BITS  = (GROW != 0) ? IN_BITS + 1 : IN_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_vld,
  input  logic [IN_NODES*IN_BITS-1:0]   in_data,
  input  logic [IN_NODES-1:0]           in_ovf,
  input  logic                          nxt_load,
  output logic                          load,
  output logic                          out_vld,
  output logic [OUT_NODES*OUT_BITS-1:0] out_data,
  output logic [OUT_NODES-1:0]          out_ovf
);

  logic [OUT_NODES*OUT_BITS-1:0] nd;
  logic [OUT_NODES-1:0]          no;

  for (genvar n = 0; n < OUT_NODES; n++) begin : g_node
    logic [IN_BITS-1:0] a;
    assign a = in_data[2*n*IN_BITS +: IN_BITS];

    if (2*n + 1 < IN_NODES) begin : g_pair
      logic [IN_BITS-1:0] b;
      logic [IN_BITS:0]   s;
      assign b = in_data[(2*n+1)*IN_BITS +: IN_BITS];
      assign s = {1'b0, a} + {1'b0, b};

      if (GROW != 0) begin : g_grow
        assign nd[n*OUT_BITS +: OUT_BITS] = s;
        assign no[n] = in_ovf[2*n] | in_ovf[2*n+1];
      end else begin : g_fix
        localparam logic [IN_BITS-1:0] SMAX = IN_BITS'(sat_max(IN_BITS));
        logic c_ovf;
        // Child overflow propagates so the root reports the true sum overflow.
        assign c_ovf = s[IN_BITS] | in_ovf[2*n] | in_ovf[2*n+1];
        assign no[n] = c_ovf;
        assign nd[n*OUT_BITS +: OUT_BITS] = ((SAT != 0) && c_ovf) ? SMAX : s[IN_BITS-1:0];
      end
    end else begin : g_pass
      assign nd[n*OUT_BITS +: OUT_BITS] = OUT_BITS'(a);
      assign no[n] = in_ovf[2*n];
    end
  end

  assign load = !out_vld || nxt_load;

  // Data only moves with a real beat, so bubbles never disturb a held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_ovf  <= '0;
    end else if (load) begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_data <= nd;
        out_ovf  <= no;
      end
    end
  end

endmodule

// File: rtl/adder_tree_stream.sv
// Pipelined N-input unsigned adder tree with valid/ready flow control.
module adder_tree_stream import adder_pkg::*; #(
  parameter int BITS = 8,
  parameter int NUM  = 4,
  parameter int GROW = 0,
  parameter int SAT  = 0,
  localparam int OBITS = obits(BITS, NUM, GROW)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  output logic                 ready,
  input  logic [NUM*BITS-1:0]  i,
  output logic [OBITS-1:0]     o,
  output logic                 ovf,
  output logic                 valid_out,
  input  logic                 ready_out
);

  localparam int L = levels(NUM);

  logic [L:0] vld_pipe;
  logic [L:0] load;

  assign load[L]     = ready_out;
  assign ready       = load[0] && !rst;
  assign vld_pipe[0] = valid && ready;

  for (genvar lv = 0; lv < L; lv++) begin : g_lvl
    localparam int IN_NODES  = nodes_at(NUM, lv);
    localparam int IN_BITS   = (GROW != 0) ? BITS + lv : BITS;
    localparam int OUT_NODES = (IN_NODES + 1) / 2;
    localparam int OUT_BITS  = (GROW != 0) ? IN_BITS + 1 : IN_BITS;

    logic [IN_NODES*IN_BITS-1:0]   din;
    logic [IN_NODES-1:0]           din_ovf;
    logic [OUT_NODES*OUT_BITS-1:0] dout;
    logic [OUT_NODES-1:0]          dout_ovf;

    if (lv == 0) begin : g_src
      assign din     = i;
      assign din_ovf = '0;
    end else begin : g_chain
      assign din     = g_lvl[lv-1].dout;
      assign din_ovf = g_lvl[lv-1].dout_ovf;
    end

    adder_tree_level #(
      .IN_NODES (IN_NODES),
      .IN_BITS  (IN_BITS),
      .GROW     (GROW),
      .SAT      (SAT)
    ) u_lvl (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (vld_pipe[lv]),
      .in_data  (din),
      .in_ovf   (din_ovf),
      .nxt_load (load[lv+1]),
      .load     (load[lv]),
      .out_vld  (vld_pipe[lv+1]),
      .out_data (dout),
      .out_ovf  (dout_ovf)
    );
  end

  // Outputs are forced quiet while rst is high so nothing leaks during reset.
  assign valid_out = vld_pipe[L] && !rst;
  assign o         = rst ? '0 : g_lvl[L-1].dout;
  assign ovf       = !rst && (GROW == 0) && g_lvl[L-1].dout_ovf[0];

endmodule

// File: tb/tb_adder_tree_stream.sv
// Scoreboard bench: four configurations share one stimulus stream, each checked against a true-sum model.
module tb_adder_tree_stream;

  typedef struct {
    logic [9:0] o;
    logic       ovf;
    int         acc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid = 1'b0;
  logic            ready_out = 1'b1;
  logic [4:0][7:0] lanes = '0;
  logic [3:0]      rdy, vo, ov;
  logic [7:0]      o0, o1, o2;
  logic [9:0]      o3;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_lat = 1'b0;
  bit   bp = 1'b0;
  exp_t q[4][$];
  int   nres[4] = '{0, 0, 0, 0};
  bit   hold[4] = '{0, 0, 0, 0};
  logic [9:0] prev_o[4];
  int   num_k[4]  = '{4, 5, 4, 4};
  int   grow_k[4] = '{0, 0, 0, 1};
  int   sat_k[4]  = '{0, 0, 1, 0};
  int   lat_k[4]  = '{2, 3, 2, 2};

  adder_tree_stream #(.BITS(8), .NUM(4), .GROW(0), .SAT(0)) dut0 (
    .clk(clk), .rst(rst), .valid(valid), .ready(rdy[0]), .i(lanes[3:0]),
    .o(o0), .ovf(ov[0]), .valid_out(vo[0]), .ready_out(ready_out));
  adder_tree_stream #(.BITS(8), .NUM(5), .GROW(0), .SAT(0)) dut1 (
    .clk(clk), .rst(rst), .valid(valid), .ready(rdy[1]), .i(lanes),
    .o(o1), .ovf(ov[1]), .valid_out(vo[1]), .ready_out(ready_out));
  adder_tree_stream #(.BITS(8), .NUM(4), .GROW(0), .SAT(1)) dut2 (
    .clk(clk), .rst(rst), .valid(valid), .ready(rdy[2]), .i(lanes[3:0]),
    .o(o2), .ovf(ov[2]), .valid_out(vo[2]), .ready_out(ready_out));
  adder_tree_stream #(.BITS(8), .NUM(4), .GROW(1), .SAT(0)) dut3 (
    .clk(clk), .rst(rst), .valid(valid), .ready(rdy[3]), .i(lanes[3:0]),
    .o(o3), .ovf(ov[3]), .valid_out(vo[3]), .ready_out(ready_out));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int k);
    exp_t e;
    int   s;
    s = 0;
    for (int j = 0; j < num_k[k]; j++) s += int'(lanes[j]);
    if (grow_k[k] != 0) begin
      e.o   = 10'(s);
      e.ovf = 1'b0;
    end else begin
      e.ovf = (s > 255);
      e.o   = (sat_k[k] != 0 && e.ovf) ? 10'd255 : 10'(s % 256);
    end
    e.acc = cyc;
    return e;
  endfunction

  task automatic mon(input int k, input logic r, input logic v, input logic [9:0] o, input logic f);
    exp_t e;
    if (rst) begin
      chk($sformatf("rst_ready%0d", k), r, 0);
      chk($sformatf("rst_vout%0d", k), v, 0);
      chk($sformatf("rst_o%0d", k), o, 0);
      chk($sformatf("rst_ovf%0d", k), f, 0);
      q[k].delete();
      hold[k] = 1'b0;
      return;
    end
    // Occupancy equals scoreboard depth; ready may only drop with every stage full.
    chk($sformatf("ready%0d", k), r, (ready_out || q[k].size() < lat_k[k]));
    if (hold[k]) begin
      chk($sformatf("hold_v%0d", k), v, 1);
      chk($sformatf("hold_o%0d", k), o, prev_o[k]);
    end
    if (v && q[k].size() == 0) chk($sformatf("spurious%0d", k), v, 0);
    if (v && ready_out && q[k].size() != 0) begin
      e = q[k].pop_front();
      chk($sformatf("o%0d", k), o, e.o);
      chk($sformatf("ovf%0d", k), f, e.ovf);
      if (chk_lat) chk($sformatf("lat%0d", k), cyc - e.acc, lat_k[k]);
      nres[k]++;
    end
    if (valid && r) q[k].push_back(model(k));
    hold[k]   = v && !ready_out;
    prev_o[k] = o;
  endtask

  initial forever begin
    @(negedge clk);
    mon(0, rdy[0], vo[0], {2'b0, o0}, ov[0]);
    mon(1, rdy[1], vo[1], {2'b0, o1}, ov[1]);
    mon(2, rdy[2], vo[2], {2'b0, o2}, ov[2]);
    mon(3, rdy[3], vo[3], o3, ov[3]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is at posedge+1; returns at posedge+1 after dut0 took the beat.
  task automatic send(input logic [4:0][7:0] v);
    int t;
    lanes = v;
    valid = 1'b1;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (rdy[0]) break;
    end
    if (t >= 200) chk("send_timeout", 0, 1);
    step();
    valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    ready_out = 1'b1;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && q[3].size() == 0) break;
    end
    if (t >= 100) chk("drain_timeout", 0, 1);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int         n0;
    logic [7:0] b;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", rdy[0], 1);
    chk("post_rst_vout", vo[0], 0);
    chk("post_rst_o", o0, 0);
    step();

    // Directed sums: basic, odd-lane wrap, saturation/growth.
    chk_lat = 1'b1;
    send({8'd0, 8'd40, 8'd30, 8'd20, 8'd10});
    drain();
    send({8'd1, 8'd1, 8'd1, 8'd100, 8'd200});
    drain();
    send({8'd0, 8'd0, 8'd0, 8'd255, 8'd255});
    drain();

    // Backpressure with ready_out pattern 1,0,0,1.
    chk_lat = 1'b0;
    n0 = nres[0];
    bp = 1'b1;
    fork
      begin
        int ph = 0;
        while (bp) begin
          ready_out = (ph % 4 == 0) || (ph % 4 == 3);
          ph++;
          step();
        end
      end
    join_none
    for (int v = 1; v <= 8; v++) begin
      b = 8'(v);
      send({5{b}});
    end
    bp = 1'b0;
    drain();
    chk("bp_count", nres[0] - n0, 8);

    // Reset with two beats in flight.
    chk_lat = 1'b1;
    send({5{8'd7}});
    send({5{8'd9}});
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", rdy[0], 1);
    chk("midrst_vout", vo[0], 0);
    chk("midrst_o", o0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_stale", vo[0], 0);
    end
    step();
    n0 = nres[0];
    send({8'd0, 8'd4, 8'd3, 8'd2, 8'd1});
    drain();
    chk("midrst_next_count", nres[0] - n0, 1);

    // Full throughput with random lanes.
    n0 = nres[0];
    valid = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      for (int j = 0; j < 5; j++) lanes[j] = 8'($urandom_range(0, 255));
      step();
    end
    valid = 1'b0;
    drain();
    chk("thr_count", nres[0] - n0, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
